// File: rtl/ocp3_nic_card_pwr_responder_if.sv
// Card-side OCP3 NIC power signalling bundle: baseboard/straps/rail PG in, sequencing outputs back.
interface ocp3_nic_card_pwr_responder_if;
  logic       iCARD_INSTALLED;
  logic       iAUX_PWR_EN;
  logic       iMAIN_PWR_EN;
  logic       iPERST_N;
  logic       iAUX_RAIL_PG;
  logic       iMAIN_RAIL_PG;
  logic       oPRSNT_N;
  logic       oPWRGD_NIC;
  logic       oAUX_VR_EN;
  logic       oMAIN_VR_EN;
  logic       oCARD_RST_N;
  logic       oFAULT;
  logic [3:0] oDBG_FSM_curr;

  // Baseboard / fixture side: drives the strap, enables and rail PGs, observes the card.
  modport master (
    output iCARD_INSTALLED, iAUX_PWR_EN, iMAIN_PWR_EN, iPERST_N, iAUX_RAIL_PG, iMAIN_RAIL_PG,
    input  oPRSNT_N, oPWRGD_NIC, oAUX_VR_EN, oMAIN_VR_EN, oCARD_RST_N, oFAULT, oDBG_FSM_curr
  );

  // Responder side.
  modport slave (
    input  iCARD_INSTALLED, iAUX_PWR_EN, iMAIN_PWR_EN, iPERST_N, iAUX_RAIL_PG, iMAIN_RAIL_PG,
    output oPRSNT_N, oPWRGD_NIC, oAUX_VR_EN, oMAIN_VR_EN, oCARD_RST_N, oFAULT, oDBG_FSM_curr
  );
endinterface

// File: rtl/ocp3_nic_card_pwr_responder.sv
// Card-side OCP3 NIC power responder: sequences AUX/MAIN VR enables, PWRGD_NIC and the
// card-ASIC reset in answer to the baseboard enables, with rail-timeout fault detection.
module ocp3_nic_card_pwr_responder #(
  parameter int unsigned CLKS_PER_MS     = 2000,
  parameter int unsigned PWRGD_DLY_MS    = 21,
  parameter int unsigned AUX_PG_TMO_MS   = 50,
  parameter int unsigned MAIN_PG_TMO_MS  = 50,
  parameter int unsigned MAIN_OFF_DLY_MS = 1
) (
  input logic                          iClk,
  input logic                          iRst,
  ocp3_nic_card_pwr_responder_if.slave bus
);

  localparam int unsigned PRE_W      = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);
  localparam int unsigned PG_DLY_CYC = PWRGD_DLY_MS * CLKS_PER_MS;
  localparam int unsigned PG_W       = (PG_DLY_CYC > 1) ? $clog2(PG_DLY_CYC + 1) : 1;
  localparam logic [PG_W-1:0] PG_LAST = PG_W'(PG_DLY_CYC - 1);
  localparam int unsigned AUX_TMO_MS = AUX_PG_TMO_MS + PWRGD_DLY_MS;

  typedef enum logic [3:0] {
    S0_NO_CARD   = 4'd0,
    S1_AUX_OFF   = 4'd1,
    S2_AUX_RAMP  = 4'd2,
    S3_AUX_ON    = 4'd3,
    S4_MAIN_RAMP = 4'd4,
    S5_MAIN_ON   = 4'd5,
    S6_FAULT     = 4'd6,
    S7_MAIN_OFF  = 4'd7
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [1:0]       aux_sync;
  logic [1:0]       main_sync;
  logic [1:0]       perst_sync;
  logic             aux_en;
  logic             main_en;
  logic             perst_n;
  logic [PRE_W-1:0] pre_cnt;
  logic [15:0]      ms_cnt;
  logic [PG_W-1:0]  pg_cnt;
  logic             tick;
  logic             aux_pg_done;
  logic             pwrgd_d;
  logic             aux_vr_en_d;
  logic             main_vr_en_d;
  logic             card_rst_n_d;
  logic             fault_d;

  // True once n_ms full milliseconds have passed since state entry (counting the current cycle).
  function automatic logic elapsed(input logic [15:0] ms, input logic t, input int unsigned n_ms);
    return (32'(ms) + 32'(t)) >= n_ms;
  endfunction

  assign aux_en      = aux_sync[1];
  assign main_en     = main_sync[1];
  assign perst_n     = perst_sync[1];
  assign tick        = (pre_cnt == PRE_LAST);
  assign aux_pg_done = bus.iAUX_RAIL_PG && (pg_cnt >= PG_LAST);
  assign bus.oDBG_FSM_curr = state;

  // Two-flop synchronizers for the asynchronous baseboard controls.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      aux_sync   <= 2'b00;
      main_sync  <= 2'b00;
      perst_sync <= 2'b00;
    end else begin
      aux_sync   <= {aux_sync[0], bus.iAUX_PWR_EN};
      main_sync  <= {main_sync[0], bus.iMAIN_PWR_EN};
      perst_sync <= {perst_sync[0], bus.iPERST_N};
    end
  end

  // Millisecond timebase restarted on every state entry; ms count saturates.
  always_ff @(posedge iClk) begin
    if (iRst || (next_state != state)) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      if (ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // AUX power-good stability counter; any PG drop in the ramp window restarts it.
  always_ff @(posedge iClk) begin
    if (iRst || (next_state != state) || (state != S2_AUX_RAMP) || !bus.iAUX_RAIL_PG)
      pg_cnt <= '0;
    else
      pg_cnt <= pg_cnt + 1'b1;
  end

  // State and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state           <= S0_NO_CARD;
      bus.oPRSNT_N    <= 1'b1;
      bus.oPWRGD_NIC  <= 1'b0;
      bus.oAUX_VR_EN  <= 1'b0;
      bus.oMAIN_VR_EN <= 1'b0;
      bus.oCARD_RST_N <= 1'b0;
      bus.oFAULT      <= 1'b0;
    end else begin
      state           <= next_state;
      bus.oPRSNT_N    <= ~bus.iCARD_INSTALLED;
      bus.oPWRGD_NIC  <= pwrgd_d;
      bus.oAUX_VR_EN  <= aux_vr_en_d;
      bus.oMAIN_VR_EN <= main_vr_en_d;
      bus.oCARD_RST_N <= card_rst_n_d;
      bus.oFAULT      <= fault_d;
    end
  end

  // Next state: card removal, then AUX enable drop, then AUX rail loss override normal flow.
  always_comb begin
    next_state = state;
    if (!bus.iCARD_INSTALLED) begin
      next_state = S0_NO_CARD;
    end else if (!aux_en && (state inside {S2_AUX_RAMP, S3_AUX_ON, S4_MAIN_RAMP,
                                           S5_MAIN_ON, S7_MAIN_OFF})) begin
      next_state = S1_AUX_OFF;
    end else if (!bus.iAUX_RAIL_PG && (state inside {S3_AUX_ON, S4_MAIN_RAMP,
                                                     S5_MAIN_ON, S7_MAIN_OFF})) begin
      next_state = S6_FAULT;
    end else begin
      case (state)
        S0_NO_CARD:   next_state = S1_AUX_OFF;
        S1_AUX_OFF:   if (aux_en) next_state = S2_AUX_RAMP;
        S2_AUX_RAMP: begin
          if (aux_pg_done)                         next_state = S3_AUX_ON;
          else if (elapsed(ms_cnt, tick, AUX_TMO_MS)) next_state = S6_FAULT;
        end
        S3_AUX_ON:    if (main_en) next_state = S4_MAIN_RAMP;
        S4_MAIN_RAMP: begin
          if (bus.iMAIN_RAIL_PG)                          next_state = S5_MAIN_ON;
          else if (elapsed(ms_cnt, tick, MAIN_PG_TMO_MS)) next_state = S6_FAULT;
          else if (!main_en)                              next_state = S3_AUX_ON;
        end
        S5_MAIN_ON: begin
          if (!main_en)                next_state = S7_MAIN_OFF;
          else if (!bus.iMAIN_RAIL_PG) next_state = S6_FAULT;
        end
        S7_MAIN_OFF:  if (elapsed(ms_cnt, tick, MAIN_OFF_DLY_MS)) next_state = S3_AUX_ON;
        S6_FAULT:     if (!aux_en) next_state = S1_AUX_OFF;
        default:      next_state = S0_NO_CARD;
      endcase
    end
  end

  // Output values for the state about to be entered; card reset tracks PERST_N only in MAIN_ON.
  always_comb begin
    pwrgd_d      = 1'b0;
    aux_vr_en_d  = 1'b0;
    main_vr_en_d = 1'b0;
    card_rst_n_d = 1'b0;
    fault_d      = 1'b0;
    case (next_state)
      S2_AUX_RAMP: aux_vr_en_d = 1'b1;
      S3_AUX_ON, S7_MAIN_OFF: begin
        aux_vr_en_d = 1'b1;
        pwrgd_d     = 1'b1;
      end
      S4_MAIN_RAMP: begin
        aux_vr_en_d  = 1'b1;
        pwrgd_d      = 1'b1;
        main_vr_en_d = 1'b1;
      end
      S5_MAIN_ON: begin
        aux_vr_en_d  = 1'b1;
        pwrgd_d      = 1'b1;
        main_vr_en_d = 1'b1;
        card_rst_n_d = perst_n;
      end
      S6_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

endmodule
